// File: rtl/bcd_serial_sub.sv
// Digit-serial packed-BCD subtractor producing |a - b| as sign-magnitude.
// One digit per clock, least-significant digit first. A final borrow out of the
// CALC pass means a < b; the FIX pass then takes the ten's complement of the
// raw result, again digit-serially, to recover the magnitude.
module bcd_serial_sub #(
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   diff,
   output logic                  neg,
   output logic                  invalid
);

   localparam int unsigned   IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]          state;
   logic [4*DIGITS-1:0] a_r;
   logic [4*DIGITS-1:0] b_r;
   logic [4*DIGITS-1:0] r_r;
   logic [IW-1:0]       idx;
   logic                borrow;

   logic                accept;
   logic                bad_in;
   logic [3:0]          x_dig;
   logic [3:0]          y_dig;
   logic signed [4:0]   t;
   logic signed [4:0]   t_fix;
   logic [3:0]          r_dig;
   logic                borrow_nxt;
   logic [4*DIGITS-1:0] r_nxt;
   logic                last_dig;

   function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] x);
      logic bad;
      bad = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (x[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

   // Request acceptance and operand validity, evaluated on the live inputs
   always_comb begin
      accept   = start && ((state == S_IDLE) || (state == S_DONE));
      bad_in   = has_bad_digit(a) || has_bad_digit(b);
      last_dig = (idx == LAST);
   end

   // Shared digit subtractor: CALC does a_i - b_i, FIX does 0 - r_i
   always_comb begin
      if (state == S_FIX) begin
         x_dig = 4'd0;
         y_dig = r_r[idx*4 +: 4];
      end else begin
         x_dig = a_r[idx*4 +: 4];
         y_dig = b_r[idx*4 +: 4];
      end
      t     = $signed({1'b0, x_dig}) - $signed({1'b0, y_dig}) - $signed({4'd0, borrow});
      t_fix = t + 5'sd10;
      if (t < 0) begin
         r_dig      = t_fix[3:0];
         borrow_nxt = 1'b1;
      end else begin
         r_dig      = t[3:0];
         borrow_nxt = 1'b0;
      end
      r_nxt = r_r;
      r_nxt[idx*4 +: 4] = r_dig;
   end

   // Control FSM plus working registers (latched operands, raw result, index, borrow)
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         a_r    <= '0;
         b_r    <= '0;
         r_r    <= '0;
         idx    <= '0;
         borrow <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  a_r    <= a;
                  b_r    <= b;
                  r_r    <= '0;
                  idx    <= '0;
                  borrow <= 1'b0;
                  state  <= bad_in ? S_DONE : S_CALC;
               end else begin
                  state  <= S_IDLE;
               end
            end
            S_CALC: begin
               r_r    <= r_nxt;
               borrow <= borrow_nxt;
               if (last_dig) begin
                  idx <= '0;
                  if (borrow_nxt) begin
                     // a < b: restart the index with a fresh borrow for the complement pass
                     borrow <= 1'b0;
                     state  <= S_FIX;
                  end else begin
                     state  <= S_DONE;
                  end
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_FIX: begin
               r_r    <= r_nxt;
               borrow <= borrow_nxt;
               if (last_dig) begin
                  idx   <= '0;
                  state <= S_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Result registers: written only when entering DONE, held otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         diff    <= '0;
         neg     <= 1'b0;
         invalid <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (accept && bad_in) begin
                  diff    <= '0;
                  neg     <= 1'b0;
                  invalid <= 1'b1;
               end
            end
            S_CALC: begin
               if (last_dig && !borrow_nxt) begin
                  diff    <= r_nxt;
                  neg     <= 1'b0;
                  invalid <= 1'b0;
               end
            end
            S_FIX: begin
               if (last_dig) begin
                  diff    <= r_nxt;
                  neg     <= 1'b1;
                  invalid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Status outputs decoded straight from the state register
   always_comb begin
      busy = (state == S_CALC) || (state == S_FIX);
      done = (state == S_DONE);
   end

endmodule

// File: tb/tb_bcd_serial_sub.sv
// Self-checking bench for bcd_serial_sub (DIGITS=4): an integer reference model
// fills a scoreboard queue at stimulus time; entries are popped when done rises.
module tb_bcd_serial_sub;

   localparam int unsigned D = 4;

   logic          clk;
   logic          rst;
   logic          start;
   logic [15:0]   a;
   logic [15:0]   b;
   logic          busy;
   logic          done;
   logic [15:0]   diff;
   logic          neg;
   logic          invalid;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [15:0] diff;
      logic        neg;
      logic        inv;
      int          lat;
   } exp_t;

   exp_t sb[$];

   bcd_serial_sub #(.DIGITS(D)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .diff    (diff),
      .neg     (neg),
      .invalid (invalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic bad_bcd(input logic [15:0] x);
      logic r;
      r = 1'b0;
      for (int i = 0; i < 4; i++) if (x[4*i +: 4] > 4'd9) r = 1'b1;
      return r;
   endfunction

   function automatic int bcd2int(input logic [15:0] x);
      int v;
      v = 0;
      for (int i = 3; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
      return v;
   endfunction

   function automatic logic [15:0] int2bcd(input int v);
      logic [15:0] r;
      int          t;
      t = v;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   task automatic push_expect(input logic [15:0] xa, input logic [15:0] xb);
      exp_t e;
      int   va;
      int   vb;
      if (bad_bcd(xa) || bad_bcd(xb)) begin
         e.diff = '0; e.neg = 1'b0; e.inv = 1'b1; e.lat = 1;
      end else begin
         va = bcd2int(xa);
         vb = bcd2int(xb);
         e.inv  = 1'b0;
         e.neg  = (va < vb);
         e.diff = int2bcd(e.neg ? vb - va : va - vb);
         e.lat  = e.neg ? 2 * D + 1 : D + 1;
      end
      sb.push_back(e);
   endtask

   // One-cycle start pulse; returns 1 time unit after the sampling edge
   task automatic issue(input logic [15:0] xa, input logic [15:0] xb);
      @(negedge clk);
      a = xa; b = xb; start = 1'b1;
      push_expect(xa, xb);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Bounded wait for done; lat counts edges with the sampling edge as edge 1
   task automatic await_done(input int lat0, output int lat, output int bc,
                             output bit to, output exp_t e);
      lat = lat0;
      bc  = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) bc++;
         @(posedge clk); #1;
         lat++;
      end
      to = (done !== 1'b1);
      if (sb.size() > 0) e = sb.pop_front();
      else begin
         e.diff = 'x; e.neg = 1'bx; e.inv = 1'bx; e.lat = -1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({busy, done, diff, neg, invalid} !== 20'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b diff=%h neg=%b inv=%b want all 0",
                  busy, done, diff, neg, invalid);
      end
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_positive;
      int lat; int bc; bit to; exp_t e;
      issue(16'h4321, 16'h1234);
      await_done(1, lat, bc, to, e);
      n_tests++;
      if (to || diff !== e.diff || diff !== 16'h3087) begin
         n_fail++; $display("FAIL pos_diff: got %h want %h", diff, e.diff);
      end
      n_tests++;
      if (neg !== e.neg || invalid !== e.inv) begin
         n_fail++; $display("FAIL pos_flags: got neg=%b inv=%b want neg=%b inv=%b", neg, invalid, e.neg, e.inv);
      end
      n_tests++;
      if (lat != e.lat || bc != D) begin
         n_fail++; $display("FAIL pos_latency: got lat=%0d busy=%0d want lat=%0d busy=%0d", lat, bc, e.lat, D);
      end
      @(posedge clk); #1;
      n_tests++;
      if (done !== 1'b0 || diff !== 16'h3087 || busy !== 1'b0) begin
         n_fail++; $display("FAIL pos_done_pulse: got done=%b busy=%b diff=%h want done=0 busy=0 diff=3087", done, busy, diff);
      end
   endtask

   task automatic test_negative;
      int lat; int bc; bit to; exp_t e;
      issue(16'h1234, 16'h4321);
      await_done(1, lat, bc, to, e);
      n_tests++;
      if (to || diff !== e.diff || neg !== e.neg) begin
         n_fail++; $display("FAIL neg_result: got diff=%h neg=%b want diff=%h neg=%b", diff, neg, e.diff, e.neg);
      end
      n_tests++;
      if (lat != e.lat || bc != 2 * D) begin
         n_fail++; $display("FAIL neg_latency: got lat=%0d busy=%0d want lat=%0d busy=%0d", lat, bc, e.lat, 2 * D);
      end
   endtask

   task automatic test_edges;
      logic [15:0] ta[6];
      logic [15:0] tb_[6];
      int lat; int bc; bit to; exp_t e;
      ta[0] = 16'h0000; tb_[0] = 16'h0001;
      ta[1] = 16'h9999; tb_[1] = 16'h9999;
      ta[2] = 16'h0000; tb_[2] = 16'h9999;
      for (int i = 3; i < 6; i++) begin
         ta[i]  = int2bcd(int'($urandom_range(0, 9999)));
         tb_[i] = int2bcd(int'($urandom_range(0, 9999)));
      end
      for (int i = 0; i < 6; i++) begin
         issue(ta[i], tb_[i]);
         await_done(1, lat, bc, to, e);
         n_tests++;
         if (to || diff !== e.diff || neg !== e.neg || invalid !== e.inv || lat != e.lat) begin
            n_fail++;
            $display("FAIL edge_case_%0d: a=%h b=%h got diff=%h neg=%b inv=%b lat=%0d want diff=%h neg=%b inv=%b lat=%0d",
                     i, ta[i], tb_[i], diff, neg, invalid, lat, e.diff, e.neg, e.inv, e.lat);
         end
      end
   endtask

   task automatic test_invalid;
      int lat; int bc; bit to; exp_t e;
      issue(16'h12A4, 16'h0001);
      await_done(1, lat, bc, to, e);
      n_tests++;
      if (to || invalid !== 1'b1 || diff !== 16'h0000 || neg !== 1'b0 || lat != e.lat || bc != 0) begin
         n_fail++;
         $display("FAIL invalid_op: got inv=%b diff=%h neg=%b lat=%0d busy=%0d want inv=1 diff=0000 neg=0 lat=1 busy=0",
                  invalid, diff, neg, lat, bc);
      end
      issue(16'h0050, 16'h0020);
      await_done(1, lat, bc, to, e);
      n_tests++;
      if (to || invalid !== e.inv || diff !== e.diff || neg !== e.neg) begin
         n_fail++; $display("FAIL invalid_clear: got inv=%b diff=%h want inv=%b diff=%h", invalid, diff, e.inv, e.diff);
      end
   endtask

   task automatic test_ignore_restart;
      int lat; int bc; bit to; exp_t e;
      issue(16'h4321, 16'h1234);
      @(posedge clk); #1;
      @(negedge clk);
      a = 16'h9999; b = 16'h0000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      await_done(3, lat, bc, to, e);
      n_tests++;
      if (to || diff !== e.diff || neg !== e.neg || lat != e.lat) begin
         n_fail++; $display("FAIL ignore_restart: got diff=%h neg=%b lat=%0d want diff=%h neg=%b lat=%0d",
                            diff, neg, lat, e.diff, e.neg, e.lat);
      end
   endtask

   task automatic test_back_to_back;
      int lat; int bc; bit to; exp_t e;
      @(negedge clk);
      a = 16'h4321; b = 16'h1234; start = 1'b1;
      push_expect(16'h4321, 16'h1234);
      @(posedge clk); #1;
      await_done(1, lat, bc, to, e);
      n_tests++;
      if (to || diff !== e.diff) begin
         n_fail++; $display("FAIL b2b_first: got diff=%h want %h", diff, e.diff);
      end
      a = 16'h0500; b = 16'h0100;
      push_expect(16'h0500, 16'h0100);
      @(posedge clk); #1;
      start = 1'b0;
      n_tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         n_fail++; $display("FAIL b2b_no_bubble: got busy=%b done=%b want busy=1 done=0", busy, done);
      end
      await_done(1, lat, bc, to, e);
      n_tests++;
      if (to || diff !== e.diff || neg !== e.neg || lat != e.lat) begin
         n_fail++; $display("FAIL b2b_second: got diff=%h neg=%b lat=%0d want diff=%h neg=%b lat=%0d",
                            diff, neg, lat, e.diff, e.neg, e.lat);
      end
   endtask

   task automatic test_reset_mid_fix;
      int done_seen;
      exp_t e;
      issue(16'h1234, 16'h4321);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      if (sb.size() > 0) e = sb.pop_front();
      n_tests++;
      if ({busy, done, diff, neg, invalid} !== 20'h0) begin
         n_fail++;
         $display("FAIL reset_mid_fix: got busy=%b done=%b diff=%h neg=%b inv=%b want all 0",
                  busy, done, diff, neg, invalid);
      end
      done_seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) done_seen++;
      end
      n_tests++;
      if (done_seen != 0) begin
         n_fail++; $display("FAIL reset_abort: got %0d active cycles after reset want 0", done_seen);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      test_reset;
      test_positive;
      test_negative;
      test_edges;
      test_invalid;
      test_ignore_restart;
      test_back_to_back;
      test_reset_mid_fix;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_serial_sub.md
Name: bcd_serial_sub

Overview:
- Digit-serial packed-BCD subtractor; the complement of the team's combinational BCD adder.
- Computes |A − B| over DIGITS BCD digits, processing one digit per clock, least-significant digit first.
- Reports the result as sign-magnitude: a magnitude plus a neg flag.
- Uses a start/busy/done handshake. Sits beside the BCD adder in the arithmetic library for decimal counters and display datapaths.

Parameters:
DIGITS, 4, number of BCD digits per operand; legal range 1 to 16.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE or DONE.
a  input  4*DIGITS  minuend, packed BCD; digit i is a[4i+3:4i].
b  input  4*DIGITS  subtrahend, packed BCD.
busy  output  1  high while in CALC or FIX.
done  output  1  one-cycle pulse; diff, neg and invalid are valid.
diff  output  4*DIGITS  magnitude |a−b|, packed BCD.
neg  output  1  1 when a < b.
invalid  output  1  1 when any digit of a or b was greater than 9 at acceptance.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE;
  - busy=0, done=0, diff=0, neg=0, invalid=0;
  - digit index, borrow and working registers are cleared.
- Reset wins over every other input, including mid-operation; an aborted operation produces no done.
- States: IDLE, CALC, FIX, DONE.
- Accepting a request, in IDLE or DONE with start=1:
  - latch a and b;
  - check every digit of both operands;
  - if any digit is greater than 9, go to DONE with invalid=1, diff=0, neg=0;
  - otherwise go to CALC with idx=0 and borrow=0.
- start is ignored in CALC and FIX, and the operands are not re-sampled.
- CALC, one digit per cycle, using signed 5-bit arithmetic:
  - t = a_idx − b_idx − borrow;
  - if t < 0, write r_idx = t + 10 and set borrow=1; otherwise write r_idx = t and set borrow=0.
- After digit DIGITS−1:
  - if the final borrow is 0: neg=0, magnitude = r, go to DONE;
  - if the final borrow is 1: go to FIX with idx=0 and a fresh fix-borrow of 0.
- FIX computes the ten's complement digit-serially, one digit per cycle:
  - t = 0 − r_idx − fborrow, with the same correction rule as CALC;
  - after digit DIGITS−1, go to DONE with neg=1.
  - The final fix-borrow is always 1 unless r = 0, which cannot occur in FIX.
- DONE:
  - lasts exactly one cycle, with done=1;
  - diff, neg and invalid are registered on entry and held until the next accepted start;
  - next state is CALC or DONE if a start is accepted there, otherwise IDLE.
- Output hold: while busy, diff, neg and invalid keep the previous result.
- Latency, counting clock edges after the start-sampling edge until the edge that sets done=1:
  - DIGITS+1 when a ≥ b;
  - 2·DIGITS+1 when a < b;
  - 1 for invalid operands.
- busy: high from the first CALC cycle through the last FIX or CALC cycle; low in IDLE and DONE.
- Edge cases:
  - a = b gives diff=0, neg=0; zero is never reported as negative;
  - with DIGITS=1, the same state sequence applies.
- Back-to-back operation: start held high in DONE begins the next operation with no IDLE bubble.

Test Plan:
- DIGITS=4, a=0x4321, b=0x1234, start pulse → busy high for 4 cycles; done at edge 5; diff=0x3087, neg=0, invalid=0.
- a=0x1234, b=0x4321 → FIX entered; done at edge 9; diff=0x3087, neg=1.
- a=0x0000, b=0x0001 → diff=0x0001, neg=1. Also a=0x9999, b=0x9999 → diff=0x0000, neg=0, done at edge 5.
- a=0x12A4, b=0x0001 → done at edge 1 with invalid=1, diff=0, neg=0, and busy never asserted. Then a valid request → invalid returns to 0.
- start re-pulsed with different operands mid-CALC → ignored; original result 0x3087 delivered. Then start held high through DONE → second operation begins the following cycle.
- rst=1 during FIX cycle 2 → next cycle busy=0, done=0, diff=0, neg=0, state IDLE; no done pulse for the aborted operation.
